int_square_calculator: RTL and testbench

INT_SQUARE_CALCULATOR -- requirements
Module: int_square_calculator

---
 rtl/sq_pkg.sv | 14 +
 rtl/int_square_calculator.sv | 103 ++++++++++
 tb/tb_int_square_calculator.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sq_pkg.sv
// Shared definitions for the integer square calculator.
// Holds the default operand width and the controller state encoding so
// that the square block and its sqrt partner agree on both.
package sq_pkg;

    localparam int SQ_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sq_state_t;

endpackage : sq_pkg

// File: rtl/int_square_calculator.sv
// Integer square calculator: sq = R * R via one shift-add step per clock.
//
// Ports
//   Clock  : single clock, all state updates on the rising edge
//   Reset  : synchronous, active-low
//   S      : start request, level; held high by requester until Done
//   R      : unsigned root operand, sampled only when a request starts
//   sq     : registered 2*WIDTH-bit square of the latched operand
//   Done   : high while sq holds the result of the current request
//   Busy   : high exactly while a calculation is in progress
//
// state | meaning
// IDLE  | waiting for S; sq keeps its last result
// CALC  | WIDTH shift-add steps, one per cycle, bit index = counter
// DONE  | result valid; wait for S to drop before accepting a new request
module int_square_calculator
    import sq_pkg::*;
#(
    parameter int WIDTH = SQ_WIDTH_DEFAULT
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               S,
    input  logic [WIDTH-1:0]   R,
    output logic [2*WIDTH-1:0] sq,
    output logic               Done,
    output logic               Busy
);

    // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sq_state_t          state;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_next;

    // Partial product for the current bit; full 2*WIDTH-bit width so the
    // running sum can never overflow.
    always_comb begin
        addend = '0;
        if (operand[cnt]) begin
            addend = {{WIDTH{1'b0}}, operand} << cnt;
        end
        acc_next = acc + addend;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state   <= IDLE;
            operand <= '0;
            acc     <= '0;
            cnt     <= '0;
            sq      <= '0;
            Done    <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (S) begin
                        operand <= R;
                        acc     <= '0;
                        cnt     <= '0;
                        Busy    <= 1'b1;
                        state   <= CALC;
                    end
                end

                // S is deliberately ignored here: a dropped request still
                // completes and is acknowledged through DONE.
                CALC: begin
                    acc <= acc_next;
                    if (cnt == LAST) begin
                        sq    <= acc_next;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    if (!S) begin
                        Done  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : int_square_calculator

// File: tb/tb_int_square_calculator.sv
// Directed bench for int_square_calculator with hand-computed squares.
module tb_int_square_calculator;

    logic        Clock;
    logic        Reset;
    logic        S;
    logic [7:0]  R;
    logic [15:0] sq;
    logic        Done;
    logic        Busy;

    int n_cmp = 0;
    int n_bad = 0;

    int_square_calculator #(.WIDTH(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .S     (S),
        .R     (R),
        .sq    (sq),
        .Done  (Done),
        .Busy  (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Waits for Done after the sampling edge; returns edges after the
    // sampling edge and how many of those samples showed Busy high.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        tick();                     // sampling edge
        if (Busy) busy_cnt++;
        while (!Done && lat < 40) begin
            tick();
            lat++;
            if (Busy) busy_cnt++;
        end
    endtask

    task automatic start_req(input logic [7:0] r);
        @(negedge Clock);
        R = r;
        S = 1'b1;
    endtask

    task automatic drop_req();
        @(negedge Clock);
        S = 1'b0;
        tick();
    endtask

    int lat, bcnt, restart;
    logic [15:0] sqt [0:16];

    initial begin
        Reset = 1'b0;
        S     = 1'b0;
        R     = 8'd0;
        repeat (2) tick();
        chk("reset_sq",   32'(sq),   32'd0);
        chk("reset_done", 32'(Done), 32'd0);
        chk("reset_busy", 32'(Busy), 32'd0);

        @(negedge Clock);
        Reset = 1'b1;
        tick();
        chk("idle_busy", 32'(Busy), 32'd0);

        // R=0
        start_req(8'd0);
        wait_done(lat, bcnt);
        chk("r0_latency", 32'(lat),  32'd8);
        chk("r0_busy_cycles", 32'(bcnt), 32'd8);
        chk("r0_sq",      32'(sq),   32'd0);
        chk("r0_done",    32'(Done), 32'd1);
        drop_req();
        chk("r0_done_clr", 32'(Done), 32'd0);

        // R=15, then hold S for 40 cycles
        start_req(8'd15);
        wait_done(lat, bcnt);
        chk("r15_sq", 32'(sq), 32'd225);
        restart = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Busy || !Done || sq != 16'd225) restart++;
        end
        chk("r15_hold", 32'(restart), 32'd0);
        drop_req();
        chk("r15_done_clr", 32'(Done), 32'd0);
        repeat (3) tick();
        chk("idle_holds_sq", 32'(sq), 32'd225);

        // R=255, one low cycle, then R=16
        start_req(8'd255);
        wait_done(lat, bcnt);
        chk("r255_sq", 32'(sq), 32'd65025);
        chk("r255_latency", 32'(lat), 32'd8);
        drop_req();
        start_req(8'd16);
        wait_done(lat, bcnt);
        chk("r16_sq", 32'(sq), 32'd256);
        drop_req();

        // R=200 reset on CALC cycle 4
        start_req(8'd200);
        tick();                       // sampling edge, CALC cycle 1 follows
        repeat (3) tick();            // CALC cycles 1..3 done
        @(negedge Clock);
        Reset = 1'b0;
        tick();
        chk("mid_rst_sq",   32'(sq),   32'd0);
        chk("mid_rst_done", 32'(Done), 32'd0);
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        R = 8'd3;                     // S still high
        wait_done(lat, bcnt);
        chk("post_rst_latency", 32'(lat), 32'd8);
        chk("post_rst_sq", 32'(sq), 32'd9);
        drop_req();

        // R=12, operand changed mid-CALC
        start_req(8'd12);
        tick();
        tick();
        @(negedge Clock);
        R = 8'd99;
        S = 1'b0;                     // drop also must not abort
        lat = 0;
        while (!Done && lat < 40) begin
            tick();
            lat++;
        end
        chk("r12_sq", 32'(sq), 32'd144);
        tick();
        chk("r12_leave_done", 32'(Done), 32'd0);

        // Squares of 0..16 for the sqrt bracket check
        for (int r = 0; r <= 16; r++) begin
            start_req(8'(r));
            wait_done(lat, bcnt);
            sqt[r] = sq;
            chk($sformatf("sq_%0d", r), 32'(sq), 32'(r * r));
            drop_req();
        end
        for (int x = 1; x <= 255; x++) begin
            int rt = 0;
            while ((rt + 1) * (rt + 1) <= x) rt++;
            chk($sformatf("bracket_%0d", x),
                32'((32'(sqt[rt]) <= x) && (x < 32'(sqt[rt + 1]))), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_int_square_calculator
